// File: rtl/psw_chain_responder.sv
// -----------------------------------------------------------------------------
// psw_chain_responder
//
// Power-switch side responder for the APC power-switch handshake. Each domain
// has a request level (enable_PD_send) from the always-on power controller.
// The responder drives the switch-cell chain enables (psw_en). Once a chain
// has settled, it returns the settled level on enable_PD_ack.
//
// Transitions are served one domain at a time to bound in-rush current. The
// lowest pending index wins, and there is no preemption. Each transition
// holds psw_en for RAMP_CYC cycles before the ack follows it. At least one
// idle cycle separates consecutive transitions.
//
// Optional build macro:
//   PSW_FAST_OFF_EN - power-down transitions skip the ramp. psw_en and ack
//                     both drop at the selecting edge, and busy stays low.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous reset, active-high
//   enable_PD_send in   [N_DOM] per-domain request level (1 = on, 0 = off)
//   enable_PD_ack  out  [N_DOM] per-domain settled switch state
//   psw_en         out  [N_DOM] switch-cell chain enables
//   busy           out  high while a ramp is in progress
//   active_dom     out  index of the domain in transition, 0 when idle
// -----------------------------------------------------------------------------
module psw_chain_responder #(
  parameter  int N_DOM    = 3,
  parameter  int RAMP_CYC = 16,
  parameter  int CNT_W    = 5,
  localparam int AW       = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DOM-1:0] enable_PD_send,
  output logic [N_DOM-1:0] enable_PD_ack,
  output logic [N_DOM-1:0] psw_en,
  output logic             busy,
  output logic [AW-1:0]    active_dom
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N_DOM-1:0] r_psw, w_psw_nxt;
  logic [N_DOM-1:0] r_ack, w_ack_nxt;
  logic             r_busy, w_busy_nxt;
  logic [AW-1:0]    r_dom, w_dom_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [N_DOM-1:0] w_pend;
  logic [N_DOM-1:0] w_sel_oh;
  logic [N_DOM-1:0] w_act_oh;
  logic [AW-1:0]    w_sel;
  logic             w_sel_vld;
  logic             w_tgt;

  // A domain is pending while its request differs from its settled state.
  assign w_pend    = enable_PD_send ^ r_ack;
  assign w_sel_vld = |w_pend;

  // Isolate the lowest set bit of the pending vector. This is the
  // fixed-priority one-hot pick.
  assign w_sel_oh  = w_pend & (~w_pend + 1'b1);
  assign w_tgt     = |(enable_PD_send & w_sel_oh);

  // Encode the pick as an index. Scan from high to low so that the lowest
  // pending index is the last assignment and wins.
  always_comb begin
    w_sel = '0;
    for (int unsigned k = N_DOM; k > 0; k--) begin
      if (w_pend[k-1]) begin
        w_sel = AW'(k - 1);
      end
    end
  end

  // One-hot mask of the domain currently ramping. It is used to copy that
  // domain's psw_en into its ack at the end of the ramp.
  always_comb begin
    w_act_oh = '0;
    for (int unsigned k = 0; k < N_DOM; k++) begin
      w_act_oh[k] = (AW'(k) == r_dom);
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    w_state_nxt = r_state;
    w_psw_nxt   = r_psw;
    w_ack_nxt   = r_ack;
    w_busy_nxt  = r_busy;
    w_dom_nxt   = r_dom;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      IDLE: begin
        if (w_sel_vld) begin
`ifdef PSW_FAST_OFF_EN
          if (!w_tgt) begin
            // Power-down completes in place: no ramp, no busy.
            w_psw_nxt = r_psw & ~w_sel_oh;
            w_ack_nxt = r_ack & ~w_sel_oh;
          end else
`endif
          begin
            w_psw_nxt   = (r_psw & ~w_sel_oh) | (w_tgt ? w_sel_oh : '0);
            w_dom_nxt   = w_sel;
            w_cnt_nxt   = CNT_W'(RAMP_CYC - 1);
            w_busy_nxt  = 1'b1;
            w_state_nxt = RAMP;
          end
        end
      end

      RAMP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          // The ack follows the latched target, not the live request. A
          // request withdrawn mid-ramp is picked up again from IDLE.
          w_ack_nxt   = (r_ack & ~w_act_oh) | (r_psw & w_act_oh);
          w_busy_nxt  = 1'b0;
          w_dom_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_psw   <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_dom   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_psw   <= w_psw_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      r_dom   <= w_dom_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign enable_PD_ack = r_ack;
  assign psw_en        = r_psw;
  assign busy          = r_busy;
  assign active_dom    = r_dom;

endmodule

// File: tb/tb_psw_chain_responder.sv
// -----------------------------------------------------------------------------
// tb_psw_chain_responder
//
// Bench for psw_chain_responder, built with RAMP_CYC = 4.
// It has three parts:
//   - a vector table covering reset and two back-to-back power-ups,
//   - hand-written multi-cycle corner sequences,
//   - a randomized run checked against an event-time reference model.
// The reference model schedules each ack completion at an absolute cycle.
// -----------------------------------------------------------------------------
module tb_psw_chain_responder;

  localparam int N   = 3;
  localparam int RMP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] send = 3'b000;
  logic [2:0] ack_o, psw_o;
  logic       busy_o;
  logic [1:0] dom_o;

  int n_cmp = 0;
  int n_bad = 0;

  psw_chain_responder #(
    .N_DOM   (N),
    .RAMP_CYC(RMP),
    .CNT_W   (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_PD_send(send),
    .enable_PD_ack (ack_o),
    .psw_en        (psw_o),
    .busy          (busy_o),
    .active_dom    (dom_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // One transition at a time. m_done holds the absolute cycle at which the
  // in-flight domain's ack is expected to take its target value.
  int         cyc    = 0;
  int         m_done = 0;
  bit         m_act  = 1'b0;
  logic [1:0] m_idx  = 2'd0;
  logic [2:0] m_psw  = 3'b000;
  logic [2:0] m_ack  = 3'b000;

  always @(posedge clk) begin : model
    logic [2:0] pend;
    logic [1:0] pick;
    cyc = cyc + 1;
    if (rst) begin
      m_psw = 3'b000;
      m_ack = 3'b000;
      m_act = 1'b0;
      m_idx = 2'd0;
    end else if (m_act) begin
      if (cyc == m_done) begin
        m_ack[m_idx] = m_psw[m_idx];
        m_act = 1'b0;
        m_idx = 2'd0;
      end
    end else begin
      pend = send ^ m_ack;
      if (pend != 3'b000) begin
        pick = 2'd0;
        for (int k = 2; k >= 0; k--) if (pend[k]) pick = 2'(k);
`ifdef PSW_FAST_OFF_EN
        if (!send[pick]) begin
          m_psw[pick] = 1'b0;
          m_ack[pick] = 1'b0;
        end else
`endif
        begin
          m_psw[pick] = send[pick];
          m_act  = 1'b1;
          m_idx  = pick;
          m_done = cyc + RMP;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    send = 3'b000;
    step();
    rst  = 1'b0;
  endtask

  typedef struct {
    logic       r;
    logic [2:0] s;
    logic [2:0] psw;
    logic [2:0] ack;
    logic       bsy;
    logic [1:0] dom;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int first;

    // ---------------- vector table ----------------
    tbl[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 3'b001, 3'b001, 3'b000, 1'b1, 2'd0};
    tbl[2]  = '{1'b0, 3'b001, 3'b001, 3'b000, 1'b1, 2'd0};
    tbl[3]  = '{1'b0, 3'b001, 3'b001, 3'b000, 1'b1, 2'd0};
    tbl[4]  = '{1'b0, 3'b001, 3'b001, 3'b000, 1'b1, 2'd0};
    tbl[5]  = '{1'b0, 3'b001, 3'b001, 3'b001, 1'b0, 2'd0};
    tbl[6]  = '{1'b0, 3'b011, 3'b011, 3'b001, 1'b1, 2'd1};
    tbl[7]  = '{1'b0, 3'b011, 3'b011, 3'b001, 1'b1, 2'd1};
    tbl[8]  = '{1'b0, 3'b011, 3'b011, 3'b001, 1'b1, 2'd1};
    tbl[9]  = '{1'b0, 3'b011, 3'b011, 3'b001, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 3'b011, 3'b011, 3'b011, 1'b0, 2'd0};
    tbl[11] = '{1'b0, 3'b011, 3'b011, 3'b011, 1'b0, 2'd0};

    for (int i = 0; i < 12; i++) begin
      rst  = tbl[i].r;
      send = tbl[i].s;
      step();
      chk($sformatf("tbl%0d_psw", i),  8'(psw_o),  8'(tbl[i].psw));
      chk($sformatf("tbl%0d_ack", i),  8'(ack_o),  8'(tbl[i].ack));
      chk($sformatf("tbl%0d_busy", i), 8'(busy_o), 8'(tbl[i].bsy));
      chk($sformatf("tbl%0d_dom", i),  8'(dom_o),  8'(tbl[i].dom));
    end

    // ---------------- all three domains at once ----------------
    do_reset();
    send  = 3'b111;
    first = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ack_o == 3'b111 && first < 0) first = k;
    end
    chk("serial_total_edges", 8'(first), 8'd14);

    // ---------------- request withdrawn mid-ramp ----------------
    do_reset();
    send = 3'b010;
    step();                                   // k=0: ramp starts
    send = 3'b000;
    step(); step(); step();                   // k=1..3
    chk("drop_busy_k3", 8'(busy_o), 8'h01);
    step();                                   // k=4: ack follows latched target
    chk("drop_ack_k4", 8'(ack_o), 8'h02);
    chk("drop_psw_k4", 8'(psw_o), 8'h02);
    step();                                   // k=5: fresh power-down starts
    chk("drop_psw_k5", 8'(psw_o), 8'h00);
`ifdef PSW_FAST_OFF_EN
    chk("drop_ack_k5", 8'(ack_o), 8'h00);
    chk("drop_busy_k5", 8'(busy_o), 8'h00);
`else
    chk("drop_ack_k5", 8'(ack_o), 8'h02);
    chk("drop_busy_k5", 8'(busy_o), 8'h01);
    step(); step(); step();                   // k=6..8
    chk("drop_ack_k8", 8'(ack_o), 8'h02);
    step();                                   // k=9
    chk("drop_ack_k9", 8'(ack_o), 8'h00);
`endif

    // ---------------- lower index waits for the running ramp ----------------
    do_reset();
    send = 3'b100;
    step();                                   // k=0: domain 2 ramps
    send = 3'b101;
    step();                                   // k=1
    chk("noprmpt_dom_k1", 8'(dom_o), 8'd2);
    step(); step(); step();                   // k=2..4
    chk("noprmpt_ack_k4", 8'(ack_o), 8'h04);
    chk("noprmpt_dom_k4", 8'(dom_o), 8'd0);
    chk("noprmpt_busy_k4", 8'(busy_o), 8'h00);
    step();                                   // k=5: domain 0 starts
    chk("noprmpt_dom_k5", 8'(dom_o), 8'd0);
    chk("noprmpt_busy_k5", 8'(busy_o), 8'h01);
    chk("noprmpt_psw_k5", 8'(psw_o), 8'h05);

    // ---------------- reset mid-ramp ----------------
    do_reset();
    send = 3'b010;
    step(); step();                           // cnt now 2
    rst = 1'b1;
    step();
    chk("rstmid_psw", 8'(psw_o), 8'h00);
    chk("rstmid_ack", 8'(ack_o), 8'h00);
    chk("rstmid_busy", 8'(busy_o), 8'h00);
    rst = 1'b0;
    step();                                   // k=0: ramp restarts
    chk("rstmid_restart_psw", 8'(psw_o), 8'h02);
    step(); step(); step();                   // k=3
    chk("rstmid_ack_k3", 8'(ack_o), 8'h00);
    step();                                   // k=4
    chk("rstmid_ack_k4", 8'(ack_o), 8'h02);

`ifdef PSW_FAST_OFF_EN
    // ---------------- fast power-down ----------------
    do_reset();
    send = 3'b111;
    for (int k = 0; k < 20; k++) step();
    chk("fast_pre_ack", 8'(ack_o), 8'h07);
    send = 3'b010;
    step();
    chk("fast_ack_1", 8'(ack_o), 8'h06);
    chk("fast_busy_1", 8'(busy_o), 8'h00);
    step();
    chk("fast_ack_2", 8'(ack_o), 8'h02);
    chk("fast_psw_2", 8'(psw_o), 8'h02);
    chk("fast_busy_2", 8'(busy_o), 8'h00);
`endif

    // ---------------- randomized vs reference model ----------------
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) send = 3'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
      chk("rnd_psw",  8'(psw_o),  8'(m_psw));
      chk("rnd_ack",  8'(ack_o),  8'(m_ack));
      chk("rnd_busy", 8'(busy_o), 8'(m_act));
      chk("rnd_dom",  8'(dom_o),  8'(m_act ? m_idx : 2'd0));
      chk("rnd_one_diff", 8'($countones(psw_o ^ ack_o) <= 1), 8'h01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psw_chain_responder.md
Name: psw_chain_responder

Overview:
- Power-switch side responder for the APC power-switch handshake: receives per-domain enable requests, drives the switch-cell enables, and returns per-domain acks once each switch chain has settled.
- Sequences one domain at a time to bound in-rush current; each transition holds for a programmable ramp time before its ack is raised or dropped.
- Sits between the always-on power controller and the switchable power domains. Also serves as the behavioural switch model in the SoC testbench.

Parameters:
- N_DOM, 3, number of switchable power domains.
- RAMP_CYC, 16, settle cycles per transition; legal range 1..2^CNT_W-1.
- CNT_W, 5, ramp counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- enable_PD_send  input  N_DOM  per-domain request level from the power controller; 1 = power on, 0 = power off.
- enable_PD_ack  output  N_DOM  per-domain ack level; equals the settled switch state.
- psw_en  output  N_DOM  switch-cell chain enables.
- busy  output  1  high while a transition is in progress (state RAMP).
- active_dom  output  $clog2(N_DOM)  index of the domain in transition; 0 when idle.

Behaviour:
- Reset: rst sampled high at an edge forces state=IDLE, psw_en=0, enable_PD_ack=0, busy=0, active_dom=0, cnt=0.
  - Reset is immediate and has no ramp.
  - Reset mid-RAMP abandons the transition.
- Pending set: pend = enable_PD_send XOR enable_PD_ack, evaluated every cycle.
- State IDLE:
  - If pend is non-zero, select i = lowest set index of pend (fixed priority).
  - At the same edge: psw_en[i] <= enable_PD_send[i], active_dom <= i, cnt <= RAMP_CYC-1, busy <= 1, state <= RAMP.
  - If pend is zero, hold all outputs.
- State RAMP:
  - If cnt != 0, cnt <= cnt-1.
  - If cnt == 0: enable_PD_ack[active_dom] <= psw_en[active_dom], busy <= 0, active_dom <= 0, state <= IDLE.
- Latency: a request level change sampled at edge t in IDLE produces the ack change at edge t+RAMP_CYC. The psw_en change appears at edge t.
- One idle cycle minimum between consecutive transitions; the next pending domain starts at the edge after the ack update.
- Request toggled back during RAMP:
  - The ramp completes to the originally latched target and the ack follows that target.
  - The residual mismatch is re-detected in IDLE and runs as a fresh transition.
  - Acks never glitch.
- Simultaneous requests on several domains are served serially, lowest index first. A lower-index request arriving mid-RAMP waits; there is no preemption.
- psw_en and enable_PD_ack change only on the active domain. At most one bit of psw_en differs from enable_PD_ack at any time.
- Only enable_PD_ack, psw_en, busy and active_dom are outputs; all are registered, with no combinational input-to-output path.

Optional Feature:
- Macro PSW_FAST_OFF_EN.
- Defined:
  - Power-down transitions (latched target 0) skip the ramp: in IDLE, psw_en[i] <= 0 and enable_PD_ack[i] <= 0 at the same edge, and the state stays IDLE.
  - busy is not asserted for power-down.
  - Power-up transitions are unchanged.
  - Power-down on domain i is one cycle from request sample to ack.
- Not defined: power-down and power-up both use the full RAMP_CYC ramp as described above.

Test Plan:
- Reset, then enable_PD_send=3'b001 (RAMP_CYC=4), change sampled at edge t -> psw_en=3'b001 at t; busy high t..t+3; enable_PD_ack=3'b001 at edge t+4; busy low at t+4.
- enable_PD_send 3'b000->3'b111 in one cycle -> domains powered in order 0,1,2; each ack 4 edges after its psw_en rise; 1 idle cycle between transitions; total 15 cycles to ack=3'b111.
- Domain 1 on, mid-RAMP drop enable_PD_send[1] -> ack[1] rises at ramp end, then psw_en[1] falls next cycle and ack[1] falls 4 edges later.
- Domain 2 in RAMP, domain 0 requests -> domain 2 completes, then domain 0 starts; active_dom sequence 2,0,0.
- rst asserted at cnt=2 during power-up of domain 1 -> next edge psw_en=0, ack=0, busy=0. After release with request still high, the full 4-cycle ramp restarts.
- PSW_FAST_OFF_EN defined, ack=3'b111, send=3'b010 -> ack[0] drops 1 cycle after sample, ack[2] 1 cycle later; busy never asserted.
